// File: rtl/star_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : star_mem_arbiter
// Brief    : Shares the 36x3 pixel RAM between the scanner, mapper and cleaner.
//            Define STAR_ARB_RR_EN for round-robin arbitration; otherwise the
//            priority is fixed at clean > map > scan.
// Revision : 1.0 - initial release
// ============================================================================
module star_mem_arbiter #(
  parameter int W_X   = 3,
  parameter int W_Y   = 3,
  parameter int W_COL = 3,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [W_X-1:0]   x0,
  input  logic [W_X-1:0]   x1,
  input  logic [W_X-1:0]   x2,
  input  logic [W_Y-1:0]   y0,
  input  logic [W_Y-1:0]   y1,
  input  logic [W_Y-1:0]   y2,
  input  logic [W_COL-1:0] wdata2,
  output logic [2:0]       grant,
  output logic [2:0]       rvalid,
  output logic [W_COL-1:0] rdata,
  output logic             err,
  output logic [5:0]       ram_addr,
  output logic             ram_wren,
  output logic [W_COL-1:0] ram_data,
  input  logic [W_COL-1:0] ram_q
);

  localparam logic [W_X:0] c_IMG_W = (W_X+1)'(IMG_W);
  localparam logic [W_Y:0] c_IMG_H = (W_Y+1)'(IMG_H);

  logic [2:0]     w_elig;
  logic           w_any;
  logic [1:0]     w_win;
  logic [W_X-1:0] w_x;
  logic [W_Y-1:0] w_y;
  logic [5:0]     w_xExt;
  logic [5:0]     w_yExt;
  logic [5:0]     w_addr;
  logic           w_oor;
  logic           r_rdOor;

  // The requester granted this cycle still holds req, so it must sit out.
  assign w_elig = req & ~grant;

`ifdef STAR_ARB_RR_EN
  logic [1:0] r_ptr;
  int         w_idx;

  // Walk the order ptr+3, ptr+2, ptr+1 so the nearest successor wins last.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    w_idx = 0;
    for (int k = 3; k >= 1; k--) begin
      w_idx = (int'(r_ptr) + k) % 3;
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = 2'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (w_any) begin
      r_ptr <= w_win;
    end
  end
`else
  always_comb begin
    w_any = |w_elig;
    w_win = 2'd0;
    if (w_elig[2]) begin
      w_win = 2'd2;
    end else if (w_elig[1]) begin
      w_win = 2'd1;
    end
  end
`endif

  always_comb begin
    w_x = x0;
    w_y = y0;
    case (w_win)
      2'd1:    begin w_x = x1; w_y = y1; end
      2'd2:    begin w_x = x2; w_y = y2; end
      default: begin w_x = x0; w_y = y0; end
    endcase
  end

  assign w_oor  = ({1'b0, w_x} >= c_IMG_W) || ({1'b0, w_y} >= c_IMG_H);
  assign w_xExt = 6'(w_x);
  assign w_yExt = 6'(w_y);
  assign w_addr = (w_yExt << 2) + (w_yExt << 1) + w_xExt;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= 3'b000;
      rvalid   <= 3'b000;
      err      <= 1'b0;
      ram_addr <= 6'd0;
      ram_wren <= 1'b0;
      ram_data <= '0;
      r_rdOor  <= 1'b0;
    end else begin
      // Read completion trails the grant by one cycle; err marks a dead read.
      rvalid  <= {1'b0, grant[1:0]};
      r_rdOor <= err;
      if (w_any) begin
        grant    <= 3'b001 << w_win;
        err      <= w_oor;
        ram_addr <= w_oor ? 6'd0 : w_addr;
        ram_wren <= (w_win == 2'd2) && !w_oor;
        if (w_win == 2'd2) begin
          ram_data <= wdata2;
        end
      end else begin
        grant    <= 3'b000;
        err      <= 1'b0;
        ram_wren <= 1'b0;
      end
    end
  end

  assign rdata = ((rvalid[0] || rvalid[1]) && !r_rdOor) ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_star_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_star_mem_arbiter
// Brief    : Directed scenarios plus randomized traffic against a shadow-memory
//            reference model for star_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_star_mem_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] x0, x1, x2, y0, y1, y2;
  logic [2:0] wdata2;
  logic [2:0] grant, rvalid, rdata;
  logic       err;
  logic [5:0] ram_addr;
  logic       ram_wren;
  logic [2:0] ram_data;
  logic [2:0] ram_q;

  logic [2:0] mem [36];
  logic [2:0] initVal [36];
  logic       memInit;

  int nVec = 0;
  int nErr = 0;

  star_mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
    .wdata2(wdata2), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .err(err), .ram_addr(ram_addr), .ram_wren(ram_wren),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 36; i++) mem[i] <= initVal[i];
    end else if (ram_wren && ram_addr < 6'd36) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= (ram_addr < 6'd36) ? mem[ram_addr] : 3'd0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    req = 3'b000; x0 = 0; x1 = 0; x2 = 0; y0 = 0; y1 = 0; y2 = 0; wdata2 = 0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nVec++;
    if ({grant, rvalid, err, ram_wren, ram_addr, ram_data, rdata} !== '0) begin
      nErr++;
      $display("FAIL reset_state: got g=%b rv=%b err=%b we=%b a=%0d d=%0d rd=%0d, want all 0",
               grant, rvalid, err, ram_wren, ram_addr, ram_data, rdata);
    end
  endtask

  task automatic test_single_read();
    req = 3'b001; x0 = 3'd2; y0 = 3'd3;
    tick();
    nVec++;
    if (grant !== 3'b001 || ram_addr !== 6'd20 || ram_wren !== 1'b0 || err !== 1'b0) begin
      nErr++;
      $display("FAIL single_grant: got g=%b a=%0d we=%b err=%b, want g=001 a=20 we=0 err=0",
               grant, ram_addr, ram_wren, err);
    end
    req = 3'b000;
    tick();
    nVec++;
    if (rvalid !== 3'b001 || rdata !== initVal[20]) begin
      nErr++;
      $display("FAIL single_rvalid: got rv=%b rd=%0d, want rv=001 rd=%0d", rvalid, rdata, initVal[20]);
    end
    tick();
  endtask

  task automatic test_write_read();
    req = 3'b100; x2 = 3'd5; y2 = 3'd5; wdata2 = 3'd0;
    tick();
    nVec++;
    if (grant !== 3'b100 || ram_addr !== 6'd35 || ram_wren !== 1'b1 || ram_data !== 3'd0) begin
      nErr++;
      $display("FAIL write_grant: got g=%b a=%0d we=%b d=%0d, want g=100 a=35 we=1 d=0",
               grant, ram_addr, ram_wren, ram_data);
    end
    req = 3'b010; x1 = 3'd5; y1 = 3'd5;
    tick();
    nVec++;
    if (rvalid !== 3'b000 || grant !== 3'b010 || ram_addr !== 6'd35 || ram_wren !== 1'b0) begin
      nErr++;
      $display("FAIL raw_grant: got rv=%b g=%b a=%0d we=%b, want rv=000 g=010 a=35 we=0",
               rvalid, grant, ram_addr, ram_wren);
    end
    req = 3'b000;
    tick();
    nVec++;
    if (rvalid !== 3'b010 || rdata !== 3'd0) begin
      nErr++;
      $display("FAIL raw_rdata: got rv=%b rd=%0d, want rv=010 rd=0", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [2:0] expSeq [6];
`ifdef STAR_ARB_RR_EN
    expSeq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
`else
    expSeq = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
`endif
    doReset();
    req = 3'b111; x0 = 3'd1; y0 = 3'd0; x1 = 3'd2; y1 = 3'd1; x2 = 3'd4; y2 = 3'd4; wdata2 = 3'd6;
    for (int c = 0; c < 6; c++) begin
      tick();
      nVec++;
      if (grant !== expSeq[c]) begin
        nErr++;
        $display("FAIL contention_%0d: got g=%b, want g=%b", c, grant, expSeq[c]);
      end
    end
    idleInputs();
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    req = 3'b001; x0 = 3'd6; y0 = 3'd0;
    tick();
    nVec++;
    if (grant !== 3'b001 || err !== 1'b1 || ram_wren !== 1'b0 || ram_addr !== 6'd0) begin
      nErr++;
      $display("FAIL oor_read_grant: got g=%b err=%b we=%b a=%0d, want g=001 err=1 we=0 a=0",
               grant, err, ram_wren, ram_addr);
    end
    req = 3'b000;
    tick();
    nVec++;
    if (rvalid !== 3'b001 || rdata !== 3'd0 || err !== 1'b0) begin
      nErr++;
      $display("FAIL oor_read_rvalid: got rv=%b rd=%0d err=%b, want rv=001 rd=0 err=0", rvalid, rdata, err);
    end
    req = 3'b100; x2 = 3'd1; y2 = 3'd7; wdata2 = 3'd5;
    tick();
    nVec++;
    if (grant !== 3'b100 || err !== 1'b1 || ram_wren !== 1'b0) begin
      nErr++;
      $display("FAIL oor_write: got g=%b err=%b we=%b, want g=100 err=1 we=0", grant, err, ram_wren);
    end
    req = 3'b000;
    tick();
    nVec++;
    if (rvalid !== 3'b000 || err !== 1'b0) begin
      nErr++;
      $display("FAIL oor_write_after: got rv=%b err=%b, want rv=000 err=0", rvalid, err);
    end
    tick();
  endtask

  task automatic test_reset_midread();
    logic [2:0] expFirst;
`ifdef STAR_ARB_RR_EN
    expFirst = 3'b010;
`else
    expFirst = 3'b100;
`endif
    req = 3'b010; x1 = 3'd1; y1 = 3'd1;
    tick();
    nVec++;
    if (grant !== 3'b010) begin
      nErr++;
      $display("FAIL midread_grant: got g=%b, want g=010", grant);
    end
    req = 3'b000;
    reset = 1'b1;
    tick();
    nVec++;
    if ({grant, rvalid, err, ram_wren, ram_addr, ram_data, rdata} !== '0) begin
      nErr++;
      $display("FAIL midread_reset: got g=%b rv=%b err=%b we=%b a=%0d d=%0d rd=%0d, want all 0",
               grant, rvalid, err, ram_wren, ram_addr, ram_data, rdata);
    end
    reset = 1'b0;
    req = 3'b111; x0 = 3'd0; y0 = 3'd2; x1 = 3'd3; y1 = 3'd3; x2 = 3'd2; y2 = 3'd2; wdata2 = 3'd1;
    tick();
    nVec++;
    if (rvalid !== 3'b000 || grant !== expFirst) begin
      nErr++;
      $display("FAIL post_reset_grant: got rv=%b g=%b, want rv=000 g=%b", rvalid, grant, expFirst);
    end
    idleInputs();
    tick();
    tick();
  endtask

  // Randomized back-to-back traffic against a transaction-level model.
  task automatic test_back_to_back(int nCyc);
    logic [2:0] act, elig, eGrant, eRvalid, eRvN, eRdata, eRdN, pendVal, eData;
    logic [2:0] ax [3];
    logic [2:0] ay [3];
    logic [2:0] aw;
    logic [2:0] shadow [36];
    logic       eErr, eWren, oor;
    logic [5:0] eAddr;
    int         ptr, win, a;

    idleInputs();
    reset = 1'b1;
    for (int i = 0; i < 36; i++) begin
      initVal[i] = 3'($urandom_range(0, 7));
      shadow[i]  = initVal[i];
    end
    memInit = 1'b1;
    tick();
    memInit = 1'b0;
    tick();
    reset = 1'b0;

    act = 3'b000; aw = 3'd0;
    for (int i = 0; i < 3; i++) begin ax[i] = 3'd0; ay[i] = 3'd0; end
    eGrant = 3'b000; eRvalid = 3'b000; eRdata = 3'd0; pendVal = 3'd0; eData = 3'd0;
    eErr = 1'b0; eWren = 1'b0; eAddr = 6'd0; ptr = 0;

    for (int c = 0; c < nCyc; c++) begin
      nVec++;
      if (grant !== eGrant || err !== eErr || ram_wren !== eWren || ram_addr !== eAddr ||
          (eWren && ram_data !== eData)) begin
        nErr++;
        $display("FAIL rand_port_%0d: got g=%b err=%b we=%b a=%0d d=%0d, want g=%b err=%b we=%b a=%0d d=%0d",
                 c, grant, err, ram_wren, ram_addr, ram_data, eGrant, eErr, eWren, eAddr, eData);
      end
      nVec++;
      if (rvalid !== eRvalid || (eRvalid != 3'b000 && rdata !== eRdata)) begin
        nErr++;
        $display("FAIL rand_read_%0d: got rv=%b rd=%0d, want rv=%b rd=%0d",
                 c, rvalid, rdata, eRvalid, eRdata);
      end

      for (int i = 0; i < 3; i++) begin
        if (act[i] && eGrant[i]) act[i] = 1'b0;
        if (!act[i] && $urandom_range(0, 99) < 60) begin
          act[i] = 1'b1;
          ax[i]  = 3'($urandom_range(0, 6));
          ay[i]  = 3'($urandom_range(0, 6));
          if (i == 2) aw = 3'($urandom_range(0, 7));
        end
      end
      req = act; x0 = ax[0]; y0 = ay[0]; x1 = ax[1]; y1 = ay[1]; x2 = ax[2]; y2 = ay[2]; wdata2 = aw;

      eRvN = {1'b0, eGrant[1:0]};
      eRdN = pendVal;
      elig = act & ~eGrant;
      win  = -1;
`ifdef STAR_ARB_RR_EN
      for (int k = 1; k <= 3; k++) begin
        if (win < 0 && elig[(ptr + k) % 3]) win = (ptr + k) % 3;
      end
`else
      for (int k = 2; k >= 0; k--) begin
        if (win < 0 && elig[k]) win = k;
      end
`endif
      if (win >= 0) begin
        oor    = (ax[win] >= 3'd6) || (ay[win] >= 3'd6);
        a      = int'(ay[win]) * 6 + int'(ax[win]);
        eGrant = 3'b001 << win;
        eErr   = oor;
        eAddr  = oor ? 6'd0 : 6'(a);
        eWren  = (win == 2) && !oor;
        if (win == 2) begin
          eData = aw;
          if (!oor) shadow[a] = aw;
        end else begin
          pendVal = oor ? 3'd0 : shadow[a];
        end
        ptr = win;
      end else begin
        eGrant = 3'b000;
        eErr   = 1'b0;
        eWren  = 1'b0;
      end
      eRvalid = eRvN;
      eRdata  = eRdN;
      tick();
    end
    idleInputs();
    tick();
    tick();
  endtask

  initial begin
    idleInputs();
    reset   = 1'b1;
    memInit = 1'b1;
    for (int i = 0; i < 36; i++) initVal[i] = 3'(i) ^ 3'b101;
    tick();
    memInit = 1'b0;
    tick();

    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_reset_midread();
    test_back_to_back(600);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
